nem_ohmux_seq: RTL and testbench



---
 rtl/nem_relay_pkg.sv | 24 ++
 rtl/nem_relay_seq.sv | 110 +++++++++++
 rtl/nem_ohmux_seq.sv | 61 ++++++
 tb/tb_nem_ohmux_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nem_relay_pkg.sv
// rtl/nem_relay_pkg.sv - shared state type and helpers for the NEM relay sequencer
package nem_relay_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2,
    ACTIVE  = 2'd3
  } relay_state_e;

  localparam int MAX_SEL_W = 64;

  // True when vec has no more than one bit set (all-zero counts as a valid disconnect).
  function automatic logic is_onehot0(input logic [MAX_SEL_W-1:0] vec);
    return (vec & (vec - MAX_SEL_W'(1))) == '0;
  endfunction

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nem_relay_seq.sv
// rtl/nem_relay_seq.sv - break-before-make relay select sequencer with settle timers
module nem_relay_seq
  import nem_relay_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int T_OPEN  = 2,
  parameter int T_CLOSE = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_IN-1:0] sel_req,
  input  logic            sel_vld,
  output logic            sel_rdy,
  output logic [N_IN-1:0] s,
  output logic            err,
  output logic            active
);

  localparam int CW = cnt_w(T_OPEN, T_CLOSE);
  localparam logic [CW-1:0] OPEN_LOAD  = CW'(T_OPEN - 1);
  localparam logic [CW-1:0] CLOSE_LOAD = CW'(T_CLOSE - 1);

  relay_state_e    state;
  logic [CW-1:0]   cnt;
  logic [N_IN-1:0] target;
  logic            accept;
  logic            req_ok;

  assign accept = sel_vld && sel_rdy;
  assign req_ok = is_onehot0(MAX_SEL_W'(sel_req));

  // sel_rdy and active are kept as registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      target  <= '0;
      s       <= '0;
      err     <= 1'b0;
      sel_rdy <= 1'b1;
      active  <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!req_ok) begin
              err <= 1'b1;
            end else if (sel_req != '0) begin
              s       <= sel_req;
              target  <= sel_req;
              cnt     <= CLOSE_LOAD;
              state   <= CLOSING;
              sel_rdy <= 1'b0;
            end
          end
        end

        ACTIVE: begin
          if (accept) begin
            if (!req_ok) begin
              err <= 1'b1;
            end else if (sel_req != s) begin
              // Release the closed relay first; the new one waits for the open timer.
              s       <= '0;
              target  <= sel_req;
              cnt     <= OPEN_LOAD;
              state   <= OPENING;
              sel_rdy <= 1'b0;
              active  <= 1'b0;
            end
          end
        end

        OPENING: begin
          if (cnt == '0) begin
            if (target == '0) begin
              state   <= IDLE;
              sel_rdy <= 1'b1;
            end else begin
              s     <= target;
              cnt   <= CLOSE_LOAD;
              state <= CLOSING;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        CLOSING: begin
          if (cnt == '0) begin
            state   <= ACTIVE;
            sel_rdy <= 1'b1;
            active  <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          state   <= IDLE;
          s       <= '0;
          sel_rdy <= 1'b1;
          active  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/nem_ohmux_seq.sv
// rtl/nem_ohmux_seq.sv - sequenced one-hot NEM mux with registered, settle-qualified output
module nem_ohmux_seq
  import nem_relay_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int WIDTH   = 8,
  parameter int T_OPEN  = 2,
  parameter int T_CLOSE = 3,
  parameter int INVERT  = 1
) (
  input  logic                  CP,
  input  logic                  RN,
  input  logic [N_IN*WIDTH-1:0] I,
  input  logic [N_IN-1:0]       SEL_REQ,
  input  logic                  SEL_VLD,
  output logic                  SEL_RDY,
  output logic [N_IN-1:0]       S,
  output logic [WIDTH-1:0]      ZN,
  output logic                  ZN_VLD,
  output logic                  ERR
);

  localparam logic [WIDTH-1:0] ZN_RST = (INVERT != 0) ? '1 : '0;

  logic             active;
  logic [WIDTH-1:0] raw;

  nem_relay_seq #(
    .N_IN    (N_IN),
    .T_OPEN  (T_OPEN),
    .T_CLOSE (T_CLOSE)
  ) u_seq (
    .clk     (CP),
    .rstn    (RN),
    .sel_req (SEL_REQ),
    .sel_vld (SEL_VLD),
    .sel_rdy (SEL_RDY),
    .s       (S),
    .err     (ERR),
    .active  (active)
  );

  // AND-OR of the gate drives; S is at most one-hot so this is a plain select.
  always_comb begin
    raw = '0;
    for (int k = 0; k < N_IN; k++) begin
      raw = raw | (I[k*WIDTH +: WIDTH] & {WIDTH{S[k]}});
    end
  end

  always_ff @(posedge CP) begin
    if (!RN) begin
      ZN     <= ZN_RST;
      ZN_VLD <= 1'b0;
    end else begin
      ZN     <= (INVERT != 0) ? ~raw : raw;
      ZN_VLD <= active;
    end
  end

endmodule

// File: tb/tb_nem_ohmux_seq.sv
// tb/tb_nem_ohmux_seq.sv - scoreboard bench for the sequenced NEM one-hot mux
module tb_nem_ohmux_seq;

  logic        cp = 1'b0;
  always #5 cp = ~cp;

  // Default configuration instance
  logic        rn_a = 1'b0;
  logic [31:0] i_a = '0;
  logic [3:0]  sel_req_a = '0;
  logic        sel_vld_a = 1'b0;
  logic        sel_rdy_a;
  logic [3:0]  s_a;
  logic [7:0]  zn_a;
  logic        zn_vld_a;
  logic        err_a;

  // Wide, non-inverting, fast-relay instance
  logic         rn_b = 1'b0;
  logic [127:0] i_b = '0;
  logic [7:0]   sel_req_b = '0;
  logic         sel_vld_b = 1'b0;
  logic         sel_rdy_b;
  logic [7:0]   s_b;
  logic [15:0]  zn_b;
  logic         zn_vld_b;
  logic         err_b;

  nem_ohmux_seq dut_a (
    .CP(cp), .RN(rn_a), .I(i_a), .SEL_REQ(sel_req_a), .SEL_VLD(sel_vld_a),
    .SEL_RDY(sel_rdy_a), .S(s_a), .ZN(zn_a), .ZN_VLD(zn_vld_a), .ERR(err_a)
  );

  nem_ohmux_seq #(.N_IN(8), .WIDTH(16), .T_OPEN(1), .T_CLOSE(1), .INVERT(0)) dut_b (
    .CP(cp), .RN(rn_b), .I(i_b), .SEL_REQ(sel_req_b), .SEL_VLD(sel_vld_b),
    .SEL_RDY(sel_rdy_b), .S(s_b), .ZN(zn_b), .ZN_VLD(zn_vld_b), .ERR(err_b)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  exp_q_a[$];
  logic [15:0] exp_q_b[$];

  logic bbm_bad_a = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Present a request on dut_a, hold until accepted (bounded), return just after edge e.
  task automatic req_a(input logic [3:0] v);
    int budget;
    sel_req_a = v;
    sel_vld_a = 1'b1;
    budget = 0;
    while (!sel_rdy_a && budget < 20) begin
      tick();
      budget++;
    end
    if (!sel_rdy_a) chk("req_a_rdy_timeout", 32'(sel_rdy_a), 32'd1);
    tick();
    sel_vld_a = 1'b0;
  endtask

  // Monitor: pop one expected word on each ZN_VLD rising edge.
  logic prev_vld_a = 1'b0;
  logic prev_vld_b = 1'b0;
  logic [3:0] prev_s_a = '0;
  always @(posedge cp) begin
    #2;
    if (zn_vld_a && !prev_vld_a) begin
      if (exp_q_a.size() == 0) chk("mon_a_unexpected_valid", 32'(zn_a), 32'hDEAD);
      else chk("mon_a_zn", 32'(zn_a), 32'(exp_q_a.pop_front()));
    end
    if (zn_vld_b && !prev_vld_b) begin
      if (exp_q_b.size() == 0) chk("mon_b_unexpected_valid", 32'(zn_b), 32'hDEAD);
      else chk("mon_b_zn", 32'(zn_b), 32'(exp_q_b.pop_front()));
    end
    if ((s_a & (s_a - 4'd1)) != 4'd0) bbm_bad_a = 1'b1;
    if (prev_s_a != 4'd0 && s_a != 4'd0 && s_a != prev_s_a) bbm_bad_a = 1'b1;
    prev_vld_a = zn_vld_a;
    prev_vld_b = zn_vld_b;
    prev_s_a   = s_a;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_a = {8'h00, 8'h0F, 8'h3C, 8'hA5};
    ticks(2);
    chk("rst_s", 32'(s_a), 32'h0);
    chk("rst_zn", 32'(zn_a), 32'hFF);
    chk("rst_zn_vld", 32'(zn_vld_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    chk("rst_rdy", 32'(sel_rdy_a), 32'h1);
    chk("rst_b_zn", 32'(zn_b), 32'h0);
    rn_a = 1'b1;
    rn_b = 1'b1;
    tick();

    // Zero request in IDLE is a no-op
    req_a(4'b0000);
    chk("idle_zero_s", 32'(s_a), 32'h0);
    chk("idle_zero_rdy", 32'(sel_rdy_a), 32'h1);

    // Select input 0 from IDLE
    exp_q_a.push_back(8'h5A);
    req_a(4'b0001);
    chk("sel0_s", 32'(s_a), 32'h1);
    chk("sel0_rdy_e0", 32'(sel_rdy_a), 32'h0);
    tick();
    chk("sel0_rdy_e1", 32'(sel_rdy_a), 32'h0);
    tick();
    chk("sel0_rdy_e2", 32'(sel_rdy_a), 32'h0);
    tick();
    chk("sel0_rdy_e3", 32'(sel_rdy_a), 32'h1);
    chk("sel0_vld_e3", 32'(zn_vld_a), 32'h0);
    tick();
    chk("sel0_vld_e4", 32'(zn_vld_a), 32'h1);
    chk("sel0_zn", 32'(zn_a), 32'h5A);

    // Same selection while ACTIVE is a no-op
    req_a(4'b0001);
    chk("same_s", 32'(s_a), 32'h1);
    chk("same_rdy", 32'(sel_rdy_a), 32'h1);
    tick();
    chk("same_vld", 32'(zn_vld_a), 32'h1);

    // Move to input 2: break, then make
    exp_q_a.push_back(8'hF0);
    req_a(4'b0100);
    chk("mv2_s_e0", 32'(s_a), 32'h0);
    tick();
    chk("mv2_s_e1", 32'(s_a), 32'h0);
    chk("mv2_vld_e1", 32'(zn_vld_a), 32'h0);
    tick();
    chk("mv2_s_e2", 32'(s_a), 32'h4);
    ticks(3);
    chk("mv2_vld_e5", 32'(zn_vld_a), 32'h0);
    tick();
    chk("mv2_vld_e6", 32'(zn_vld_a), 32'h1);
    chk("mv2_zn", 32'(zn_a), 32'hF0);

    // Two-hot request is rejected with a single ERR pulse
    req_a(4'b0110);
    chk("err_pulse", 32'(err_a), 32'h1);
    chk("err_s", 32'(s_a), 32'h4);
    chk("err_vld", 32'(zn_vld_a), 32'h1);
    chk("err_zn", 32'(zn_a), 32'hF0);
    tick();
    chk("err_clear", 32'(err_a), 32'h0);
    chk("err_s2", 32'(s_a), 32'h4);

    // Go to input 1, then disconnect
    exp_q_a.push_back(8'hC3);
    req_a(4'b0010);
    ticks(6);
    chk("sel1_zn", 32'(zn_a), 32'hC3);
    req_a(4'b0000);
    chk("disc_s_e0", 32'(s_a), 32'h0);
    chk("disc_rdy_e0", 32'(sel_rdy_a), 32'h0);
    tick();
    chk("disc_vld_e1", 32'(zn_vld_a), 32'h0);
    tick();
    chk("disc_rdy_e2", 32'(sel_rdy_a), 32'h1);
    chk("disc_s_e2", 32'(s_a), 32'h0);
    chk("disc_zn", 32'(zn_a), 32'hFF);

    // Reset while CLOSING, then a clean re-request
    req_a(4'b0001);
    tick();
    rn_a = 1'b0;
    tick();
    rn_a = 1'b1;
    chk("rstmid_s", 32'(s_a), 32'h0);
    chk("rstmid_vld", 32'(zn_vld_a), 32'h0);
    chk("rstmid_rdy", 32'(sel_rdy_a), 32'h1);
    exp_q_a.push_back(8'h5A);
    req_a(4'b0001);
    ticks(4);
    chk("rereq_vld", 32'(zn_vld_a), 32'h1);
    chk("rereq_zn", 32'(zn_a), 32'h5A);

    // Wide non-inverting instance with one-cycle relay timing
    i_b[7*16 +: 16] = 16'h1234;
    exp_q_b.push_back(16'h1234);
    sel_req_b = 8'h80;
    sel_vld_b = 1'b1;
    tick();
    sel_vld_b = 1'b0;
    chk("b_s", 32'(s_b), 32'h80);
    tick();
    chk("b_vld_e1", 32'(zn_vld_b), 32'h0);
    tick();
    chk("b_vld_e2", 32'(zn_vld_b), 32'h1);
    chk("b_zn", 32'(zn_b), 32'h1234);
    i_b[7*16 +: 16] = 16'hABCD;
    tick();
    chk("b_latency", 32'(zn_b), 32'hABCD);

    ticks(2);
    chk("bbm_a", 32'(bbm_bad_a), 32'h0);
    chk("queue_a_drained", 32'(exp_q_a.size()), 32'h0);
    chk("queue_b_drained", 32'(exp_q_b.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
